// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the control FSM and the shared memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state
// and raise illegal; otherwise they retire as a NOP.
// state_o encoding: FETCH=0 DECODE=1 EXEC_R=2 EXEC_I=3 ADDR=4 MEM_RD=5
// MEM_WR=6 WB_ALU=7 WB_MEM=8 WB_IMM=9 BRANCH=10 EXEC_JALR=11 JUMP=12
// JUMP_R=13 TRAP=14.
module multicycle_ctrl #(
  parameter int unsigned Width  = 32,
  parameter int unsigned StateW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Width-1:0]      inst,
  input  logic                  branch_taken,
  multicycle_ctrl_if.master     mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_src,
  output logic [1:0]            alu_a_sel,
  output logic [1:0]            alu_b_sel,
  output logic [1:0]            alu_op,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  illegal,
  output logic [StateW-1:0]     state_o
);

  typedef enum logic [StateW-1:0] {
    S_FETCH     = StateW'(0),
    S_DECODE    = StateW'(1),
    S_EXEC_R    = StateW'(2),
    S_EXEC_I    = StateW'(3),
    S_ADDR      = StateW'(4),
    S_MEM_RD    = StateW'(5),
    S_MEM_WR    = StateW'(6),
    S_WB_ALU    = StateW'(7),
    S_WB_MEM    = StateW'(8),
    S_WB_IMM    = StateW'(9),
    S_BRANCH    = StateW'(10),
    S_EXEC_JALR = StateW'(11),
    S_JUMP      = StateW'(12),
    S_JUMP_R    = StateW'(13)
`ifdef ILLEGAL_TRAP_EN
    ,S_TRAP     = StateW'(14)
`endif
  } state_t;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign unused_inst = ^inst[Width-1:7];

  // State register; reset lands in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky illegal flag, set on the DECODE -> TRAP transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  // Illegal flag update.
  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && state_d == S_TRAP) illegal_d = 1'b1;
  end
`endif

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OpR:             state_d = S_EXEC_R;
          OpI:             state_d = S_EXEC_I;
          OpLoad, OpStore: state_d = S_ADDR;
          OpBr:            state_d = S_BRANCH;
          OpJal:           state_d = S_JUMP;
          OpJalr:          state_d = S_EXEC_JALR;
          OpLui:           state_d = S_WB_IMM;
          OpAuipc:         state_d = S_WB_ALU;
`ifdef ILLEGAL_TRAP_EN
          default:         state_d = S_TRAP;
`else
          default:         state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:    state_d = S_WB_ALU;
      S_EXEC_I:    state_d = S_WB_ALU;
      S_ADDR:      state_d = inst[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    if (mem.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:    if (mem.mem_ready) state_d = S_FETCH;
      S_WB_ALU:    state_d = S_FETCH;
      S_WB_MEM:    state_d = S_FETCH;
      S_WB_IMM:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_EXEC_JALR: state_d = S_JUMP_R;
      S_JUMP:      state_d = S_FETCH;
      S_JUMP_R:    state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode of the current state; everything is forced low during reset.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 2'd0;
    alu_op       = 2'd0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_a_sel   = 2'd1;
        alu_b_sel   = 2'd2;
        ir_we       = mem.mem_ready;
        pc_we       = mem.mem_ready;
      end
      S_DECODE: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 2'd1;
      end
      S_EXEC_R: alu_op = 2'd2;
      S_EXEC_I: begin
        alu_b_sel = 2'd1;
        alu_op    = 2'd3;
      end
      S_ADDR:   alu_b_sel = 2'd1;
      S_MEM_RD: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.addr_sel = 1'b1;
      end
      S_WB_ALU: reg_we = 1'b1;
      S_WB_MEM: begin
        reg_we = 1'b1;
        wb_sel = 2'd1;
      end
      S_WB_IMM: begin
        reg_we = 1'b1;
        wb_sel = 2'd3;
      end
      S_BRANCH: begin
        alu_op = 2'd1;
        pc_we  = branch_taken;
        pc_src = 2'd1;
      end
      S_EXEC_JALR: alu_b_sel = 2'd1;
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'd1;
        reg_we = 1'b1;
        wb_sel = 2'd2;
      end
      S_JUMP_R: begin
        pc_we  = 1'b1;
        pc_src = 2'd2;
        reg_we = 1'b1;
        wb_sel = 2'd2;
      end
      default: ;
    endcase
    if (rst) begin
      mem.mem_req  = 1'b0;
      mem.mem_we   = 1'b0;
      mem.addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      alu_a_sel    = 2'd0;
      alu_b_sel    = 2'd0;
      alu_op       = 2'd0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
    end
  end

  assign state_o = rst ? '0 : state_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_q & ~rst;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected
// per-cycle control vector, a monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       reg_we;
    logic [1:0] wb;
    logic       ill;
  } exp_t;

  localparam int K_RST = 0, K_FW = 1, K_FR = 2, K_DEC = 3, K_ER = 4, K_EI = 5,
                 K_ADDR = 6, K_MR = 7, K_MW = 8, K_WBA = 9, K_WBM = 10,
                 K_WBI = 11, K_BNT = 12, K_BT = 13, K_EJ = 14, K_J = 15,
                 K_JR = 16, K_TRAP = 17;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0040A103;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_ADDI  = 32'h00508093;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        branch_taken;
  logic        ir_we, pc_we, reg_we, illegal;
  logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel;
  logic [3:0]  state_o;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.Width(32), .StateW(4)) dut (
    .clk(clk), .rst(rst), .inst(inst), .branch_taken(branch_taken),
    .mem(mem_if.master), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  // Expected control vector for each state/condition, straight from the state table.
  function automatic exp_t ev(input int k);
    exp_t e = '0;
    case (k)
      K_FW:   begin e.st = 4'd0; e.mem_req = 1; e.a = 2'd1; e.b = 2'd2; end
      K_FR:   begin e.st = 4'd0; e.mem_req = 1; e.a = 2'd1; e.b = 2'd2; e.ir_we = 1; e.pc_we = 1; end
      K_DEC:  begin e.st = 4'd1; e.a = 2'd2; e.b = 2'd1; end
      K_ER:   begin e.st = 4'd2; e.op = 2'd2; end
      K_EI:   begin e.st = 4'd3; e.b = 2'd1; e.op = 2'd3; end
      K_ADDR: begin e.st = 4'd4; e.b = 2'd1; end
      K_MR:   begin e.st = 4'd5; e.mem_req = 1; e.addr_sel = 1; end
      K_MW:   begin e.st = 4'd6; e.mem_req = 1; e.mem_we = 1; e.addr_sel = 1; end
      K_WBA:  begin e.st = 4'd7; e.reg_we = 1; end
      K_WBM:  begin e.st = 4'd8; e.reg_we = 1; e.wb = 2'd1; end
      K_WBI:  begin e.st = 4'd9; e.reg_we = 1; e.wb = 2'd3; end
      K_BNT:  begin e.st = 4'd10; e.op = 2'd1; e.pc_src = 2'd1; end
      K_BT:   begin e.st = 4'd10; e.op = 2'd1; e.pc_src = 2'd1; e.pc_we = 1; end
      K_EJ:   begin e.st = 4'd11; e.b = 2'd1; end
      K_J:    begin e.st = 4'd12; e.pc_we = 1; e.pc_src = 2'd1; e.reg_we = 1; e.wb = 2'd2; end
      K_JR:   begin e.st = 4'd13; e.pc_we = 1; e.pc_src = 2'd2; e.reg_we = 1; e.wb = 2'd2; end
      K_TRAP: begin e.st = 4'd14; e.ill = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock cycle of stimulus: drive inputs after the edge and queue the expectation.
  task automatic step(input logic r, input logic [31:0] i, input logic mr,
                      input logic bt, input int k, input string nm);
    @(posedge clk);
    #1;
    rst               = r;
    inst              = i;
    mem_if.mem_ready  = mr;
    branch_taken      = bt;
    exp_q.push_back(ev(k));
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT's control vector mid-cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t  got, want;
    string nm;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {state_o, mem_if.mem_req, mem_if.mem_we, mem_if.addr_sel, ir_we, pc_we,
              pc_src, alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, illegal};
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  end

  initial begin
    rst = 1'b1; inst = '0; mem_if.mem_ready = 1'b0; branch_taken = 1'b0;
    // Reset: outputs forced low even with mem_ready high
    step(1, 0, 1, 0, K_RST, "rst_a");
    step(1, 0, 1, 0, K_RST, "rst_b");
    // ADD: 4 cycles, mem_ready ignored outside memory states
    step(0, I_ADD, 1, 0, K_FR,  "add_fetch");
    step(0, I_ADD, 1, 0, K_DEC, "add_dec");
    step(0, I_ADD, 1, 0, K_ER,  "add_exec");
    step(0, I_ADD, 0, 0, K_WBA, "add_wb");
    // LW with two wait cycles: 7 cycles
    step(0, I_LW, 1, 0, K_FR,   "lw_fetch");
    step(0, I_LW, 0, 0, K_DEC,  "lw_dec");
    step(0, I_LW, 1, 0, K_ADDR, "lw_addr");
    step(0, I_LW, 0, 0, K_MR,   "lw_wait1");
    step(0, I_LW, 0, 0, K_MR,   "lw_wait2");
    step(0, I_LW, 1, 0, K_MR,   "lw_done");
    step(0, I_LW, 0, 0, K_WBM,  "lw_wb");
    // SW with one wait cycle
    step(0, I_SW, 1, 0, K_FR,   "sw_fetch");
    step(0, I_SW, 0, 0, K_DEC,  "sw_dec");
    step(0, I_SW, 0, 0, K_ADDR, "sw_addr");
    step(0, I_SW, 0, 0, K_MW,   "sw_wait");
    step(0, I_SW, 1, 0, K_MW,   "sw_done");
    // BEQ not taken, then taken
    step(0, I_BEQ, 1, 1, K_FR,  "beq0_fetch");
    step(0, I_BEQ, 0, 1, K_DEC, "beq0_dec");
    step(0, I_BEQ, 0, 0, K_BNT, "beq0_br");
    step(0, I_BEQ, 1, 0, K_FR,  "beq1_fetch");
    step(0, I_BEQ, 0, 0, K_DEC, "beq1_dec");
    step(0, I_BEQ, 0, 1, K_BT,  "beq1_br");
    // JAL
    step(0, I_JAL, 1, 0, K_FR,  "jal_fetch");
    step(0, I_JAL, 0, 0, K_DEC, "jal_dec");
    step(0, I_JAL, 0, 0, K_J,   "jal_jump");
    // JALR
    step(0, I_JALR, 1, 0, K_FR,  "jalr_fetch");
    step(0, I_JALR, 0, 0, K_DEC, "jalr_dec");
    step(0, I_JALR, 0, 0, K_EJ,  "jalr_exec");
    step(0, I_JALR, 0, 0, K_JR,  "jalr_jump");
    // LUI, AUIPC, ADDI
    step(0, I_LUI, 1, 0, K_FR,    "lui_fetch");
    step(0, I_LUI, 0, 0, K_DEC,   "lui_dec");
    step(0, I_LUI, 0, 0, K_WBI,   "lui_wb");
    step(0, I_AUIPC, 1, 0, K_FR,  "auipc_fetch");
    step(0, I_AUIPC, 0, 0, K_DEC, "auipc_dec");
    step(0, I_AUIPC, 0, 0, K_WBA, "auipc_wb");
    step(0, I_ADDI, 1, 0, K_FR,   "addi_fetch");
    step(0, I_ADDI, 0, 0, K_DEC,  "addi_dec");
    step(0, I_ADDI, 0, 0, K_EI,   "addi_exec");
    step(0, I_ADDI, 0, 0, K_WBA,  "addi_wb");
    // Reset during a FETCH wait
    step(0, I_ADD, 0, 0, K_FW,  "fw_wait1");
    step(0, I_ADD, 0, 0, K_FW,  "fw_wait2");
    step(1, I_ADD, 1, 0, K_RST, "fw_rst1");
    step(1, I_ADD, 1, 0, K_RST, "fw_rst2");
    step(0, I_ADD, 0, 0, K_FW,  "fw_resume");
    // Reset during a MEM_RD wait: no writeback afterwards
    step(0, I_LW, 1, 0, K_FR,   "lwr_fetch");
    step(0, I_LW, 0, 0, K_DEC,  "lwr_dec");
    step(0, I_LW, 0, 0, K_ADDR, "lwr_addr");
    step(0, I_LW, 0, 0, K_MR,   "lwr_wait");
    step(1, I_LW, 1, 0, K_RST,  "lwr_rst");
    step(0, I_LW, 0, 0, K_FW,   "lwr_resume");
    // Unknown opcode
    step(0, I_BAD, 1, 0, K_FR,  "bad_fetch");
    step(0, I_BAD, 0, 0, K_DEC, "bad_dec");
`ifdef ILLEGAL_TRAP_EN
    step(0, I_BAD, 1, 0, K_TRAP, "trap1");
    step(0, I_BAD, 1, 1, K_TRAP, "trap2");
    step(0, I_ADD, 1, 0, K_TRAP, "trap3");
    step(1, I_ADD, 1, 0, K_RST,  "trap_rst");
    step(0, I_ADD, 0, 0, K_FW,   "trap_resume");
`else
    step(0, I_BAD, 0, 0, K_FW,  "bad_nop_fetch");
    step(0, I_ADD, 1, 0, K_FR,  "bad_next_fetch");
    step(0, I_ADD, 0, 0, K_DEC, "bad_next_dec");
`endif
    repeat (2) @(posedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
